instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction fetch front end that produces the instruction fields consumed by the decode/control logic: op, funct3, funct7 and the register indices.
- Owns the PC register and runs a single-outstanding req/gnt/rvalid handshake to instruction memory.
- Holds each fetched instruction until decode accepts it, then selects the next PC from the pc_src encoding produced by decode (00 PC+4, 01 branch/JAL target, 10 JALR target).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FETCH_TIMEOUT, 255, cycles in WAIT without rvalid before fetch_err (8-bit counter, range 1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
instr_valid  out  1  held instruction valid
instr_ready  in  1  decode accepts held instruction
instr  out  32  held instruction word
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]
rd  out  5  instr[11:7]
rs1  out  5  instr[19:15]
rs2  out  5  instr[24:20]
pc_out  out  32  PC of held instruction
pc_src  in  2  next-PC select, sampled on accept
branch_target  in  32  pc_out+imm, used when pc_src=01
jalr_target  in  32  rs1+imm, used when pc_src=10
fetch_err  out  1  sticky timeout error
misalign_err  out  1  sticky misaligned-target error (see Optional Feature)

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - pc=RESET_PC; state=FETCH.
  - imem_req=0 while rst_n=0; it asserts in the first cycle after release.
  - instr_valid=0; instr=32'h0000_0013 (NOP); field outputs decode the NOP; pc_out=RESET_PC.
  - fetch_err=0; misalign_err=0; timeout counter=0.
- Field outputs are combinational slices of the instr register.
- States are FETCH, WAIT, HOLD and ERR.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_addr stays stable while req=1 and gnt=0.
  - On gnt, go to WAIT and clear the counter.
- WAIT:
  - imem_req=0.
  - On rvalid: instr<=imem_rdata, pc_out<=pc, go to HOLD.
  - Each cycle without rvalid the counter increments. When the counter reaches FETCH_TIMEOUT, set fetch_err=1 and go to ERR.
- HOLD:
  - instr_valid=1; instr and pc_out are stable.
  - On instr_ready, pc is loaded as follows:
    - pc_src 00 and 11 (reserved): pc_out+4.
    - pc_src 01: branch_target.
    - pc_src 10: {jalr_target[31:1],1'b0}.
  - Then go to FETCH; instr_valid=0 from the next cycle.
- ERR: imem_req=0, instr_valid=0. ERR is held until reset.
- Latency:
  - gnt in cycle t, rvalid in t+1, instr_valid in t+2.
  - Accept in t+2 gives imem_req with the new address in t+3.
  - Best-case throughput is one instruction per 3 cycles.
- imem_rvalid outside WAIT is ignored, including in the same cycle as gnt.
- Memory must not return a response for a request issued before reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0.
- pc_src, branch_target and jalr_target are don't-care except in an accept cycle.
- Reset asserted in any state aborts the current fetch immediately and restarts from RESET_PC.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: on accept, if the selected next PC has bit[1]=1 (JALR already clears bit 0):
  - set misalign_err=1, enter ERR, issue no fetch;
  - pc holds the offending target for debug.
- Undefined:
  - next-PC bits [1:0] are forced to 00 (silent truncation);
  - misalign_err is tied 0.

Test Plan:
- Reset release with gnt=1 and rvalid one cycle later returning 32'h00500093 -> imem_addr=0, instr_valid at cycle 2, op=7'h13, rd=1, funct3=0; accept with pc_src=00 -> next imem_addr=4.
- gnt held low 3 cycles -> imem_req stays high with imem_addr constant; then gnt=1 and rvalid two cycles later -> instruction captured once, pc_out correct.
- Accept with pc_src=01, branch_target=32'h0000_0100 -> next imem_addr=32'h100; pc_src=10, jalr_target=32'h0000_0203 -> next imem_addr=32'h200 (macro undefined).
- HOLD with instr_ready=0 for 5 cycles -> instr_valid stays 1, instr and pc_out unchanged, no imem_req; a spurious rvalid during this time is ignored.
- WAIT with no rvalid for FETCH_TIMEOUT=4 -> fetch_err=1 at the 4th cycle, imem_req=0 thereafter; rst_n pulse -> fetch_err=0 and fetch restarts at RESET_PC.
- MISALIGN_TRAP_EN defined: accept with pc_src=01, branch_target=32'h0000_0102 -> misalign_err=1, no further imem_req.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem handshake, held instr.
// Define MISALIGN_TRAP_EN to trap on next-PC bit[1]=1 instead of truncating.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] pc_out,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic        fetch_err,
  output logic        misalign_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [7:0]  TO  = FETCH_TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [31:0] next_pc;
  logic [31:0] tgt;
  logic        mis;
  logic        mis_q;

  assign cnt_nxt = cnt + 8'd1;

  always_comb begin
    next_pc = pc_out + 32'd4;
    unique case (1'b1)
      pc_src == 2'b01: next_pc = branch_target;
      pc_src == 2'b10: next_pc = jalr_target & 32'hFFFF_FFFE;
      default:         next_pc = pc_out + 32'd4;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign tgt = next_pc;
  assign mis = next_pc[1];
`else
  assign tgt = next_pc & 32'hFFFF_FFFC;
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      instr       <= NOP;
      instr_valid <= 1'b0;
      cnt         <= 8'd0;
      fetch_err   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_gnt) begin
            state <= S_WAIT;
            cnt   <= 8'd0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == TO) begin
              fetch_err <= 1'b1;
              state     <= S_ERR;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc          <= tgt;
            instr_valid <= 1'b0;
            if (mis) begin
              mis_q <= 1'b1;
              state <= S_ERR;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
      endcase
    end
  end

  // Request is gated by rst_n so it stays low while reset is held.
  assign imem_req     = rst_n && (state == S_FETCH);
  assign imem_addr    = pc;
  assign misalign_err = mis_q;

  assign op     = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

endmodule
